prog_clock_divider: RTL and testbench
=====================================

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of divide counter and divide value.
REQ-002 SHALL have parameter DIV_DEFAULT, default 5000000: half-period in clk cycles after reset; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter MOD, default 60: modulus of the tick counter; legal range >= 2.
REQ-004 SHALL have parameter MOD_W, default 6: width of tick_cnt; MOD_W >= ceil(log2(MOD)).
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  count enable; 0 freezes counting state.
REQ-008 load  input  1  one-cycle request to load div_in as new half-period.
REQ-009 div_in  input  CNT_W  requested half-period in cycles; 0 is illegal.
REQ-010 clk_out  output  1  registered divided square wave, period 2*div_cur cycles.
REQ-011 tick  output  1  registered one-cycle pulse coincident with each clk_out 0->1 transition.
REQ-012 tick_cnt  output  MOD_W  count of ticks modulo MOD.
REQ-013 wrap  output  1  registered one-cycle pulse when tick_cnt wraps MOD-1 -> 0.
REQ-014 div_cur  output  CNT_W  half-period currently in effect.

Function
REQ-015 Internal counter cnt SHALL run 0..div_cur-1 on every clk edge with en=1; terminal count (TC) = en and cnt==div_cur-1.
REQ-016 At TC, cnt SHALL return to 0 and clk_out SHALL invert on the same edge.
REQ-017 tick SHALL be 1 for exactly the cycle after a TC edge that drives clk_out 0->1; 0 otherwise, including after 1->0 toggles.
REQ-018 On each tick-producing TC, tick_cnt SHALL increment by 1; from MOD-1 it SHALL go to 0 and wrap SHALL pulse for that same cycle.
REQ-019 load with div_in != 0 SHALL capture div_in into a pending register and set a pending flag; load with div_in == 0 SHALL be ignored (no state change).
REQ-020 With en=1, a pending value SHALL become div_cur only at a TC edge (glitch-free retiming); clk_out half-periods SHALL never be truncated or stretched by a load.
REQ-021 load in the same cycle as TC SHALL take effect at that TC; a later load before the next TC SHALL overwrite the pending value (last write wins).
REQ-022 With en=0, a pending value (or same-cycle load) SHALL be applied to div_cur on the next edge and cnt SHALL clear to 0; clk_out and tick_cnt SHALL hold.
REQ-023 With en=0, cnt, clk_out and tick_cnt SHALL hold and tick and wrap SHALL be 0.
REQ-024 Deasserting then reasserting en SHALL resume from the held cnt with no extra or missing toggle.
REQ-025 div_cur == 1 SHALL give clk_out toggling every cycle (period 2) and tick every second cycle.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W bits with no overflow at div_cur = 2^CNT_W-1.

Reset
REQ-027 reset SHALL take priority over en and load on the same edge.
REQ-028 On reset, cnt=0, clk_out=0, tick=0, wrap=0, tick_cnt=0, div_cur=DIV_DEFAULT, pending flag cleared.
REQ-029 Reset mid-period SHALL discard any pending load; first toggle after release SHALL occur on the DIV_DEFAULT-th enabled edge.

Verification (DIV_DEFAULT=3, MOD=4, CNT_W=8)
REQ-030 Reset, then en=1 constant -> clk_out rises on edge 3, falls on edge 6, period 6; tick high only the cycle after edges 3, 9, 15.
REQ-031 Run 4 ticks -> tick_cnt 1,2,3,0; wrap high only with the 4th tick; no wrap at other ticks.
REQ-032 load div_in=5 mid half-period at cnt=1 -> current half-period still 3 cycles; following half-periods 5 cycles; div_cur=5 after that TC.
REQ-033 load div_in=0 -> div_cur, period and pending state unchanged; then load 2 then load 4 before TC -> div_cur becomes 4.
REQ-034 en=0 for 10 cycles at cnt=1 -> outputs frozen, tick/wrap 0; en=1 -> toggle after 2 further edges; load 2 while en=0 -> div_cur=2 next edge, cnt=0.
REQ-035 reset asserted with en=1 and load=1 same edge -> all outputs at reset values, div_cur=3, load discarded.

Source files
------------

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - programmable square-wave clock divider with tick counter and glitch-free divisor reload
module prog_clock_divider #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 5000000,
  parameter int          MOD         = 60,
  parameter int          MOD_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic [MOD_W-1:0] tick_cnt,
  output logic             wrap,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MOD_W-1:0] TICK_ONE  = MOD_W'(1);
  localparam logic [MOD_W-1:0] TICK_LAST = MOD_W'(MOD - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_val;
  logic             pend_vld;

  logic             load_ok;
  logic [CNT_W-1:0] cnt_last;
  logic             tc;
  logic             rise;
  logic             apply_div;
  logic [CNT_W-1:0] next_div;
  logic             retime;

  // A zero divisor would stall the counter, so such loads are dropped entirely.
  assign load_ok   = load && (div_in != '0);
  // div_cur is never 0, so this subtraction cannot underflow, and cnt never
  // needs to reach div_cur itself, so 2^CNT_W-1 needs no extra counter bit.
  assign cnt_last  = div_cur - CNT_ONE;
  assign tc        = en && (cnt == cnt_last);
  assign rise      = tc && !clk_out;
  // A same-cycle load beats an older pending value (last write wins).
  assign apply_div = load_ok || pend_vld;
  assign next_div  = load_ok ? div_in : pend_val;
  // Divisor changes are only allowed where no half-period is in progress:
  // at a terminal count, or while the divider is stopped.
  assign retime    = !en || tc;

  // Half-period counter and output square wave.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (!en) begin
      if (apply_div) begin
        cnt <= '0;
      end
    end else if (tc) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Divisor in effect plus the pending reload waiting for a safe edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cur  <= DIV_RST;
      pend_val <= '0;
      pend_vld <= 1'b0;
    end else if (retime) begin
      if (apply_div) begin
        div_cur  <= next_div;
      end
      pend_vld <= 1'b0;
    end else if (load_ok) begin
      pend_val <= div_in;
      pend_vld <= 1'b1;
    end
  end

  // Rising-edge tick, modulo tick counter and wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick <= rise;
      wrap <= rise && (tick_cnt == TICK_LAST);
      if (rise) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + TICK_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - table-driven self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] div_in;
  logic       clk_out;
  logic       tick;
  logic [1:0] tick_cnt;
  logic       wrap;
  logic [7:0] div_cur;

  int n_tests = 0;
  int n_fail  = 0;

  prog_clock_divider #(
    .CNT_W      (8),
    .DIV_DEFAULT(3),
    .MOD        (4),
    .MOD_W      (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick),
    .tick_cnt(tick_cnt),
    .wrap    (wrap),
    .div_cur (div_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic       l;
    logic [7:0] d;
    int         reps;
    logic       eclk;
    logic       etick;
    logic [1:0] etcnt;
    logic       ewrap;
    logic [7:0] ediv;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic l, input logic [7:0] d,
                              input int reps, input logic eclk, input logic etick,
                              input logic [1:0] etcnt, input logic ewrap, input logic [7:0] ediv);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.d = d; v.reps = reps;
    v.eclk = eclk; v.etick = etick; v.etcnt = etcnt; v.ewrap = ewrap; v.ediv = ediv;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic e, input logic l, input logic [7:0] d);
    reset  = r;
    en     = e;
    load   = l;
    div_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic eclk, input logic etick,
                     input logic [1:0] etcnt, input logic ewrap, input logic [7:0] ediv);
    n_tests++;
    if ({clk_out, tick, tick_cnt, wrap, div_cur} !== {eclk, etick, etcnt, ewrap, ediv}) begin
      n_fail++;
      $display("FAIL %s: got clk_out=%b tick=%b tick_cnt=%0d wrap=%b div_cur=%0d, expected clk_out=%b tick=%b tick_cnt=%0d wrap=%b div_cur=%0d",
               name, clk_out, tick, tick_cnt, wrap, div_cur, eclk, etick, etcnt, ewrap, ediv);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; div_in = '0;

    // reset beats en and load on the same edge
    add(1, 1, 1, 8'd7, 1, 0, 0, 0, 0, 3);
    add(1, 0, 0, 8'd0, 1, 0, 0, 0, 0, 3);
    // free run, default half-period 3: rises on 3,9,15,21, falls on 6,12,18
    add(0, 1, 0, 8'd0, 2, 0, 0, 0, 0, 3);
    add(0, 1, 0, 8'd0, 1, 1, 1, 1, 0, 3);
    add(0, 1, 0, 8'd0, 2, 1, 0, 1, 0, 3);
    add(0, 1, 0, 8'd0, 3, 0, 0, 1, 0, 3);
    add(0, 1, 0, 8'd0, 1, 1, 1, 2, 0, 3);
    add(0, 1, 0, 8'd0, 2, 1, 0, 2, 0, 3);
    add(0, 1, 0, 8'd0, 3, 0, 0, 2, 0, 3);
    add(0, 1, 0, 8'd0, 1, 1, 1, 3, 0, 3);
    add(0, 1, 0, 8'd0, 2, 1, 0, 3, 0, 3);
    add(0, 1, 0, 8'd0, 3, 0, 0, 3, 0, 3);
    add(0, 1, 0, 8'd0, 1, 1, 1, 0, 1, 3);
    add(0, 1, 0, 8'd0, 1, 1, 0, 0, 0, 3);
    // load 5 at cnt=1: current half-period stays 3, then 5-cycle halves
    add(0, 1, 1, 8'd5, 1, 1, 0, 0, 0, 3);
    add(0, 1, 0, 8'd0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 8'd0, 4, 0, 0, 0, 0, 5);
    add(0, 1, 0, 8'd0, 1, 1, 1, 1, 0, 5);
    add(0, 1, 0, 8'd0, 4, 1, 0, 1, 0, 5);
    add(0, 1, 0, 8'd0, 1, 0, 0, 1, 0, 5);
    // load 0 ignored, then load 2, load 4 before TC: 4 wins
    add(0, 1, 1, 8'd0, 1, 0, 0, 1, 0, 5);
    add(0, 1, 1, 8'd2, 1, 0, 0, 1, 0, 5);
    add(0, 1, 1, 8'd4, 1, 0, 0, 1, 0, 5);
    add(0, 1, 0, 8'd0, 1, 0, 0, 1, 0, 5);
    add(0, 1, 0, 8'd0, 1, 1, 1, 2, 0, 4);
    add(0, 1, 0, 8'd0, 3, 1, 0, 2, 0, 4);
    add(0, 1, 0, 8'd0, 1, 0, 0, 2, 0, 4);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        drive(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d);
        chk($sformatf("row%0d.%0d", i, k), tbl[i].eclk, tbl[i].etick, tbl[i].etcnt,
            tbl[i].ewrap, tbl[i].ediv);
      end
    end

    // enable freeze at cnt=1, resume toggles after 2 more edges
    drive(1, 0, 0, 8'd0);
    drive(0, 1, 0, 8'd0); chk("frz_pre", 0, 0, 0, 0, 3);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 8'd0);
      chk($sformatf("frz%0d", k), 0, 0, 0, 0, 3);
    end
    drive(0, 1, 0, 8'd0); chk("resume1", 0, 0, 0, 0, 3);
    drive(0, 1, 0, 8'd0); chk("resume2", 1, 1, 1, 0, 3);

    // load 2 while disabled: applied next edge, cnt cleared
    drive(0, 1, 0, 8'd0); chk("dis_pre", 1, 0, 1, 0, 3);
    drive(0, 0, 1, 8'd2); chk("dis_load", 1, 0, 1, 0, 2);
    drive(0, 1, 0, 8'd0); chk("dis_e1", 1, 0, 1, 0, 2);
    drive(0, 1, 0, 8'd0); chk("dis_e2", 0, 0, 1, 0, 2);
    drive(0, 1, 0, 8'd0); chk("dis_e3", 0, 0, 1, 0, 2);
    drive(0, 1, 0, 8'd0); chk("dis_e4", 1, 1, 2, 0, 2);

    // div_cur=1: toggle every edge, tick every second edge, wrap at 3->0
    drive(0, 0, 1, 8'd1); chk("d1_load", 1, 0, 2, 0, 1);
    drive(0, 1, 0, 8'd0); chk("d1_e1", 0, 0, 2, 0, 1);
    drive(0, 1, 0, 8'd0); chk("d1_e2", 1, 1, 3, 0, 1);
    drive(0, 1, 0, 8'd0); chk("d1_e3", 0, 0, 3, 0, 1);
    drive(0, 1, 0, 8'd0); chk("d1_e4", 1, 1, 0, 1, 1);
    drive(0, 1, 0, 8'd0); chk("d1_e5", 0, 0, 0, 0, 1);

    // load coincident with TC takes effect at that TC
    drive(0, 1, 1, 8'd3); chk("tcld_0", 1, 1, 1, 0, 3);
    drive(0, 1, 0, 8'd0); chk("tcld_1", 1, 0, 1, 0, 3);
    drive(0, 1, 0, 8'd0); chk("tcld_2", 1, 0, 1, 0, 3);
    drive(0, 1, 0, 8'd0); chk("tcld_3", 0, 0, 1, 0, 3);

    // reset mid-period discards a pending load
    drive(0, 1, 1, 8'd7); chk("rstp_ld", 0, 0, 1, 0, 3);
    drive(1, 1, 0, 8'd0); chk("rstp_rst", 0, 0, 0, 0, 3);
    drive(0, 1, 0, 8'd0); chk("rstp_e1", 0, 0, 0, 0, 3);
    drive(0, 1, 0, 8'd0); chk("rstp_e2", 0, 0, 0, 0, 3);
    drive(0, 1, 0, 8'd0); chk("rstp_e3", 1, 1, 1, 0, 3);

    // maximum divisor 255: no wrap-around of the counter arithmetic
    drive(0, 0, 1, 8'd255); chk("max_load", 1, 0, 1, 0, 255);
    for (int k = 0; k < 254; k++) drive(0, 1, 0, 8'd0);
    chk("max_254", 1, 0, 1, 0, 255);
    drive(0, 1, 0, 8'd0); chk("max_255", 0, 0, 1, 0, 255);
    for (int k = 0; k < 254; k++) drive(0, 1, 0, 8'd0);
    chk("max_509", 0, 0, 1, 0, 255);
    drive(0, 1, 0, 8'd0); chk("max_510", 1, 1, 2, 0, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
